// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bnn_pkg
// Description : Definitions shared across the binary-network datapath.
//               Holds the default map geometry used by Conv2d and its
//               consumers, the feature-map serializer state type, and a
//               counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bnn_pkg;

    // Default geometry shared with the Conv2d stage
    localparam int C_DEF_IMG_SIZE = 28;
    localparam int C_DEF_OC       = 8;

    // Feature-map serializer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } fmap_ser_state_t;

    // Bits needed to count 0..n-1, never less than one bit
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fmap_serializer.sv
`default_nettype none
// ============================================================================
// Module      : fmap_serializer
// Description : Captures OC binary feature maps (IMG_SIZE x IMG_SIZE bits
//               each) on a start request and streams them out as bytes over
//               a valid/ready handshake: channel 0..OC-1, byte 0..last within
//               each channel, LSB-first bit order, zero padding past the end
//               of each map.
//
// Ports       : clk      - clock, rising edge
//               rst      - synchronous active-high reset
//               start    - capture img_in and begin a frame (IDLE only)
//               img_in   - OC packed maps of IMG_SIZE*IMG_SIZE bits
//               tx_data  - current output byte (0 when not sending)
//               tx_valid - tx_data holds a valid byte
//               tx_ready - downstream accepts tx_data
//               busy     - high while the frame is being sent
//               done     - single-cycle pulse after the last byte
// Revision    : 1.0 - initial release
// ============================================================================
module fmap_serializer
    import bnn_pkg::*;
#(
    parameter int OC       = C_DEF_OC,
    parameter int IMG_SIZE = C_DEF_IMG_SIZE
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [IMG_SIZE*IMG_SIZE-1:0]   img_in [0:OC-1],
    output logic [7:0]                     tx_data,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    output logic                           busy,
    output logic                           done
);

    localparam int N             = IMG_SIZE * IMG_SIZE;
    localparam int BYTES_PER_MAP = (N + 7) / 8;
    localparam int PW            = BYTES_PER_MAP * 8;   // map width padded to whole bytes
    localparam int CW            = clog2_min1(OC);
    localparam int BW            = clog2_min1(BYTES_PER_MAP);

    localparam logic [CW-1:0] C_CH_LAST   = CW'(OC - 1);
    localparam logic [BW-1:0] C_BYTE_LAST = BW'(BYTES_PER_MAP - 1);

    fmap_ser_state_t r_state;
    logic [CW-1:0]   r_ch;
    logic [BW-1:0]   r_byte;
    logic [PW-1:0]   r_snap [0:OC-1];

    logic            w_capture;
    logic            w_xfer;
    logic            w_last;
    logic [BW+2:0]   w_base;

    assign w_capture = (r_state == IDLE) && start;
    assign w_xfer    = (r_state == SEND) && tx_ready;
    assign w_last    = (r_ch == C_CH_LAST) && (r_byte == C_BYTE_LAST);
    assign w_base    = {r_byte, 3'b000};

    // ------------------------------------------------------------------------
    // Control: state and byte/channel counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ch    <= '0;
            r_byte  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= SEND;
                        r_ch    <= '0;
                        r_byte  <= '0;
                    end
                end
                SEND: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state <= DONE;
                            r_ch    <= '0;
                            r_byte  <= '0;
                        end else if (r_byte == C_BYTE_LAST) begin
                            // channel rollover on the same edge keeps the stream gapless
                            r_byte <= '0;
                            r_ch   <= r_ch + 1'b1;
                        end else begin
                            r_byte <= r_byte + 1'b1;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Snapshot: zero-extended to whole bytes so the tail byte pads with 0.
    // Contents are irrelevant outside SEND, so no reset is applied.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int c = 0; c < OC; c++) begin
                r_snap[c] <= PW'(img_in[c]);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign tx_valid = (r_state == SEND);
    assign busy     = (r_state == SEND);
    assign done     = (r_state == DONE);
    assign tx_data  = tx_valid ? r_snap[r_ch][w_base +: 8] : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_fmap_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fmap_serializer
// Description : Self-checking bench for fmap_serializer. A default-size
//               instance is exercised with structured and random maps and
//               random/patterned back-pressure against a byte-list reference
//               model; a 3x3, 2-channel instance checks tail padding.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fmap_serializer;
    import bnn_pkg::*;

    localparam int OC    = 8;
    localparam int IMG   = 28;
    localparam int N     = IMG * IMG;
    localparam int BPM   = (N + 7) / 8;
    localparam int TOTAL = OC * BPM;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, tx_ready;
    logic [N-1:0] img [0:OC-1];
    logic [7:0]   tx_data;
    logic         tx_valid, busy, done;

    fmap_serializer #(.OC(OC), .IMG_SIZE(IMG)) u_dut (
        .clk(clk), .rst(rst), .start(start), .img_in(img),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    logic         start2, ready2;
    logic [8:0]   img2 [0:1];
    logic [7:0]   data2;
    logic         valid2, busy2, done2;

    fmap_serializer #(.OC(2), .IMG_SIZE(3)) u_dut_small (
        .clk(clk), .rst(rst), .start(start2), .img_in(img2),
        .tx_data(data2), .tx_valid(valid2), .tx_ready(ready2),
        .busy(busy2), .done(done2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    byte unsigned exp_q[$];
    byte unsigned got_q[$];
    int stall_err, last_xfer_cyc, done_cyc, done_busy;
    logic first_valid, first_busy;

    // ---------------- reference model ----------------
    function automatic void build_model();
        logic [7:0] b;
        exp_q.delete();
        for (int c = 0; c < OC; c++) begin
            for (int k = 0; k < BPM; k++) begin
                b = 8'h00;
                for (int i = 0; i < 8; i++)
                    if (8*k + i < N) b[i] = img[c][8*k + i];
                exp_q.push_back(b);
            end
        end
    endfunction

    function automatic int count_mism();
        int m = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] != exp_q[i]) m++;
        return m;
    endfunction

    task automatic set_alternating();
        for (int c = 0; c < OC; c++) img[c] = (c % 2 == 0) ? '1 : '0;
    endtask

    task automatic set_random();
        for (int c = 0; c < OC; c++)
            for (int i = 0; i < N; i++) img[c][i] = 1'($urandom_range(0, 1));
    endtask

    task automatic kick();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Records handshaked bytes until done is seen, a byte budget is hit, or
    // the cycle budget runs out. mode: 0 ready always, 1 ready 1,0,0,1, 2 random.
    task automatic collect(input int mode, input int max_cyc, input int disturb_cyc,
                           input int abort_n);
        logic       pv, pr, rdy;
        logic [7:0] pd;
        got_q.delete();
        stall_err = 0; last_xfer_cyc = -1; done_cyc = -1; done_busy = -1;
        first_valid = tx_valid;
        first_busy  = busy;
        pv = 1'b0; pr = 1'b1; pd = 8'h00;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            tx_ready = rdy;
            start    = (cyc == disturb_cyc);
            if (cyc == disturb_cyc)
                for (int c = 0; c < OC; c++) img[c] = ~img[c];
            if (pv && !pr && (tx_valid !== 1'b1 || tx_data !== pd)) stall_err++;
            if (done === 1'b1) begin
                done_cyc  = cyc;
                done_busy = int'(busy);
                break;
            end
            if (tx_valid === 1'b1 && rdy) begin
                got_q.push_back(tx_data);
                last_xfer_cyc = cyc;
            end
            if (abort_n > 0 && got_q.size() == abort_n) break;
            pv = tx_valid; pr = rdy; pd = tx_data;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (tx_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", tx_valid); else n_pass++;
        n_checks++; if (tx_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", tx_data); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_alternating();
        set_alternating();
        build_model();
        kick();
        collect(0, TOTAL + 20, -1, 0);
        n_checks++; if (first_valid !== 1'b1 || first_busy !== 1'b1)
            $display("FAIL alt_latency valid=%b busy=%b exp=1,1", first_valid, first_busy); else n_pass++;
        n_checks++; if (got_q.size() != TOTAL) $display("FAIL alt_count got=%0d exp=%0d", got_q.size(), TOTAL); else n_pass++;
        n_checks++; if (count_mism() != 0) $display("FAIL alt_bytes mismatches=%0d exp=0", count_mism()); else n_pass++;
        n_checks++; if (got_q.size() > BPM && (got_q[BPM-1] != 8'hFF || got_q[BPM] != 8'h00))
            $display("FAIL alt_boundary got=%h,%h exp=ff,00", got_q[BPM-1], got_q[BPM]); else n_pass++;
        n_checks++; if (last_xfer_cyc != TOTAL - 1) $display("FAIL alt_no_bubble last=%0d exp=%0d", last_xfer_cyc, TOTAL-1); else n_pass++;
        n_checks++; if (done_cyc != TOTAL || done_busy != 0)
            $display("FAIL alt_done cyc=%0d busy=%0d exp=%0d,0", done_cyc, done_busy, TOTAL); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0)
            $display("FAIL alt_done_width done=%b busy=%b valid=%b exp=0,0,0", done, busy, tx_valid); else n_pass++;
    endtask

    task automatic test_single_bit();
        int nz;
        @(posedge clk); #1;
        for (int c = 0; c < OC; c++) img[c] = '0;
        img[0][0] = 1'b1;
        kick();
        collect(0, TOTAL + 20, -1, 0);
        nz = 0;
        for (int i = 1; i < got_q.size(); i++) if (got_q[i] != 8'h00) nz++;
        n_checks++; if (got_q.size() != TOTAL) $display("FAIL bit_count got=%0d exp=%0d", got_q.size(), TOTAL); else n_pass++;
        n_checks++; if (got_q.size() == 0 || got_q[0] != 8'h01)
            $display("FAIL bit_first got=%h exp=01", (got_q.size() > 0) ? got_q[0] : 8'hEE); else n_pass++;
        n_checks++; if (nz != 0) $display("FAIL bit_rest nonzero=%0d exp=0", nz); else n_pass++;
    endtask

    task automatic test_stall();
        @(posedge clk); #1;
        set_alternating();
        build_model();
        kick();
        collect(1, 3 * TOTAL, -1, 0);
        n_checks++; if (stall_err != 0) $display("FAIL stall_hold errors=%0d exp=0", stall_err); else n_pass++;
        n_checks++; if (got_q.size() != TOTAL) $display("FAIL stall_count got=%0d exp=%0d", got_q.size(), TOTAL); else n_pass++;
        n_checks++; if (count_mism() != 0) $display("FAIL stall_bytes mismatches=%0d exp=0", count_mism()); else n_pass++;
    endtask

    task automatic test_random();
        @(posedge clk); #1;
        set_random();
        build_model();
        kick();
        collect(2, 4 * TOTAL, -1, 0);
        n_checks++; if (got_q.size() != TOTAL) $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), TOTAL); else n_pass++;
        n_checks++; if (count_mism() != 0) $display("FAIL rand_bytes mismatches=%0d exp=0", count_mism()); else n_pass++;
        n_checks++; if (stall_err != 0) $display("FAIL rand_hold errors=%0d exp=0", stall_err); else n_pass++;
        n_checks++; if (done_cyc < 0) $display("FAIL rand_done got=timeout exp=pulse"); else n_pass++;
    endtask

    task automatic test_small();
        byte unsigned q[$];
        logic [7:0] exp2 [0:3];
        logic [7:0] a;
        int dcyc;
        exp2[0] = 8'hFF; exp2[1] = 8'h01; exp2[2] = 8'hFF; exp2[3] = 8'h01;
        dcyc = -1;
        img2[0] = '1; img2[1] = '1;
        ready2 = 1'b1; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (done2 === 1'b1) begin dcyc = cyc; break; end
            if (valid2 === 1'b1 && ready2) q.push_back(data2);
            @(posedge clk); #1;
        end
        n_checks++; if (q.size() != 4) $display("FAIL small_count got=%0d exp=4", q.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            a = (i < q.size()) ? q[i] : 8'hEE;
            n_checks++; if (a !== exp2[i]) $display("FAIL small_byte%0d got=%h exp=%h", i, a, exp2[i]); else n_pass++;
        end
        n_checks++; if (dcyc != 4 || busy2 !== 1'b0) $display("FAIL small_done cyc=%0d busy=%b exp=4,0", dcyc, busy2); else n_pass++;
        ready2 = 1'b0;
    endtask

    task automatic test_abort();
        int dones;
        @(posedge clk); #1;
        set_random();
        build_model();
        kick();
        collect(0, TOTAL, -1, 50);
        n_checks++; if (got_q.size() != 50 || count_mism() != 0)
            $display("FAIL abort_prefix got=%0d mism=%0d exp=50,0", got_q.size(), count_mism()); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) $display("FAIL abort_valid valid=%b busy=%b exp=0,0", tx_valid, busy); else n_pass++;
        dones = int'(done);
        repeat (3) begin @(posedge clk); #1; dones += int'(done); end
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; dones += int'(done); end
        n_checks++; if (dones != 0) $display("FAIL abort_no_done pulses=%0d exp=0", dones); else n_pass++;
        kick();
        collect(0, TOTAL + 20, -1, 0);
        n_checks++; if (got_q.size() != TOTAL || count_mism() != 0)
            $display("FAIL abort_restart got=%0d mism=%0d exp=%0d,0", got_q.size(), count_mism(), TOTAL); else n_pass++;
    endtask

    task automatic test_snapshot();
        @(posedge clk); #1;
        set_random();
        build_model();
        kick();
        collect(0, TOTAL + 20, 10, 0);
        n_checks++; if (got_q.size() != TOTAL) $display("FAIL snap_count got=%0d exp=%0d", got_q.size(), TOTAL); else n_pass++;
        n_checks++; if (count_mism() != 0) $display("FAIL snap_bytes mismatches=%0d exp=0", count_mism()); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL snap_no_restart busy=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        set_alternating();
        build_model();
        kick();
        collect(0, TOTAL + 20, -1, 0);
        n_checks++; if (done_cyc != TOTAL) $display("FAIL b2b_first_done cyc=%0d exp=%0d", done_cyc, TOTAL); else n_pass++;
        start = 1'b1;                       // seen in DONE: ignored
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL b2b_done_start busy=%b exp=0", busy); else n_pass++;
        @(posedge clk); #1;                 // start held through IDLE: captured
        start = 1'b0;
        n_checks++; if (busy !== 1'b1 || tx_valid !== 1'b1)
            $display("FAIL b2b_restart busy=%b valid=%b exp=1,1", busy, tx_valid); else n_pass++;
        set_random();                       // frame already captured from the alternating maps
        collect(0, TOTAL + 20, -1, 0);
        n_checks++; if (got_q.size() != TOTAL || count_mism() != 0)
            $display("FAIL b2b_bytes got=%0d mism=%0d exp=%0d,0", got_q.size(), count_mism(), TOTAL); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tx_ready = 1'b0;
        start2 = 1'b0; ready2 = 1'b0;
        for (int c = 0; c < OC; c++) img[c] = '0;
        img2[0] = '0; img2[1] = '0;
        @(posedge clk); #1;
        test_reset();
        test_alternating();
        test_single_bit();
        test_stall();
        test_random();
        test_small();
        test_abort();
        test_snapshot();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fmap_serializer.md
FMAP_SERIALIZER -- requirements
Module: fmap_serializer

Interface
REQ-001 Parameter OC, default 8: number of feature-map channels.
REQ-002 Parameter IMG_SIZE, default 28: map side length; bits per map N = IMG_SIZE*IMG_SIZE.
REQ-003 Parameter BYTES_PER_MAP, default ceil(N/8), derived and not overridden: 98 at the default IMG_SIZE.
REQ-004 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port start, input, 1: request to capture the maps and stream them out.
REQ-007 Port img_in, input, unpacked array [0:OC-1] of N bits: binary feature maps in the same packed layout the Conv2d output uses.
REQ-008 Port tx_data, output, 8: current output byte.
REQ-009 Port tx_valid, output, 1: tx_data holds a valid byte.
REQ-010 Port tx_ready, input, 1: downstream accepts tx_data.
REQ-011 Port busy, output, 1: high while a frame is being captured or sent.
REQ-012 Port done, output, 1: one-cycle pulse at frame completion.

Function
REQ-013 FSM states SHALL be IDLE, SEND and DONE only.
REQ-014 In IDLE with start=1, the block SHALL snapshot all of img_in into an internal register, clear the channel and byte counters, and enter SEND on the next edge.
REQ-015 tx_valid SHALL assert in the first cycle after the start edge, a latency of 1 cycle.
REQ-016 Byte k of channel c SHALL carry snapshot bits [8k+7:8k], with bit 8k on tx_data[0]; bit positions at or above N SHALL read as 0.
REQ-017 Send order SHALL be channel 0..OC-1, and byte 0..BYTES_PER_MAP-1 within each channel; the total is OC*BYTES_PER_MAP bytes (784 at defaults).
REQ-018 A transfer SHALL occur only in a cycle where tx_valid and tx_ready are both 1.
REQ-019 While tx_valid=1 and tx_ready=0, tx_data SHALL hold steady and tx_valid SHALL stay high.
REQ-020 Sustained tx_ready=1 SHALL give one byte per cycle with no bubbles, including across channel boundaries.
REQ-021 The byte counter SHALL wrap from BYTES_PER_MAP-1 to 0 and the channel counter SHALL increment on the same edge.
REQ-022 When byte BYTES_PER_MAP-1 of channel OC-1 transfers, the block SHALL deassert tx_valid on the next cycle and enter DONE.
REQ-023 DONE SHALL last exactly one cycle: done=1, busy=0, then the block returns to IDLE.
REQ-024 start SHALL be ignored in SEND and DONE; a start in IDLE on the cycle after DONE SHALL begin a new frame.
REQ-025 busy SHALL be 1 exactly while in SEND.
REQ-026 Changes on img_in after the capture edge SHALL NOT affect the frame in flight.
REQ-027 tx_ready asserted while tx_valid=0 SHALL have no effect.

Reset
REQ-028 rst=1 SHALL force the FSM to IDLE and drive tx_valid=0, tx_data=0, busy=0, done=0, with both counters at 0.
REQ-029 rst asserted mid-frame SHALL abort the frame immediately: no further bytes are sent, done is not pulsed, and snapshot contents are don't-care.
REQ-030 rst SHALL take priority over start in the same cycle.

Structure
REQ-031 The shared bnn package SHALL hold the fmap_ser_state_t enum (IDLE, SEND, DONE) and the default IMG_SIZE/OC constants shared with Conv2d.
REQ-032 Counter widths SHALL be $clog2 of their range, with a minimum of 1 bit.
REQ-033 No sub-module is required; byte selection SHALL be an indexed part-select on the snapshot.

Verification
REQ-034 Defaults; channel c = all ones for c even, all zeros for c odd; start with tx_ready=1 -> 784 bytes on consecutive cycles, 98×0xFF then 98×0x00 alternating; done on the cycle after the last byte.
REQ-035 Channel 0 bit 0 = 1, all other bits 0 -> first byte 0x01, the other 783 bytes 0x00.
REQ-036 tx_ready toggles 1,0,0,1 repeatedly -> tx_data stable during every stall, byte sequence identical to REQ-034, no byte lost or duplicated.
REQ-037 IMG_SIZE=3, OC=2, all map bits 1 -> 4 bytes sent: 0xFF, 0x01, 0xFF, 0x01 (padding zeros).
REQ-038 rst asserted after byte 50 -> tx_valid=0 on the next cycle, no done pulse; a new start then sends a full frame beginning at channel 0, byte 0.
REQ-039 img_in flipped and start re-pulsed during SEND -> output matches the original snapshot and the extra start is ignored.
